// File: rtl/shader_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shader_update_ctrl_if
// Brief    : Staging write port, shader memory port and status of the
//            tear-free shader update controller.
// Revision : 1.0
// ============================================================================
interface shader_update_ctrl_if #(
   parameter int NUM_INSTR = 10,
   parameter int INSTR_W   = 8
);
   localparam int c_cnt_w = $clog2(NUM_INSTR + 1);

   logic               wr_valid_i;
   logic [INSTR_W-1:0] wr_instr_i;
   logic               wr_ready_o;
   logic               abort_i;
   logic               vblank_i;
   logic               mem_shift_o;
   logic               mem_load_o;
   logic [INSTR_W-1:0] mem_instr_o;
   logic               pending_o;
   logic               busy_o;
   logic               done_o;
   logic [c_cnt_w-1:0] stage_cnt_o;

   modport master (
      output wr_valid_i, wr_instr_i, abort_i, vblank_i,
      input  wr_ready_o, mem_shift_o, mem_load_o, mem_instr_o,
             pending_o, busy_o, done_o, stage_cnt_o
   );

   modport slave (
      input  wr_valid_i, wr_instr_i, abort_i, vblank_i,
      output wr_ready_o, mem_shift_o, mem_load_o, mem_instr_o,
             pending_o, busy_o, done_o, stage_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/shader_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shader_update_ctrl
// Brief    : Stages a full shader program and replays it into shader memory
//            only during vertical blanking. Optional macro
//            SHADER_CTRL_COMMIT_CNT_EN adds an 8-bit commit counter output.
// Revision : 1.0
// ============================================================================
module shader_update_ctrl #(
   parameter int NUM_INSTR = 10,
   parameter int INSTR_W   = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   shader_update_ctrl_if.slave bus
`ifdef SHADER_CTRL_COMMIT_CNT_EN
   ,
   output logic [7:0]          commit_cnt_o
`endif
);
   localparam int c_cnt_w = $clog2(NUM_INSTR + 1);
   localparam int c_idx_w = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
   localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(NUM_INSTR);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_INSTR - 1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_ARMED   = 2'd1,
      S_COMMIT  = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e             r_state, w_state_next;
   logic [c_cnt_w-1:0] r_count, w_count_next;
   logic [c_idx_w-1:0] r_idx, w_idx_next;
   logic [INSTR_W-1:0] r_stage [NUM_INSTR];
   logic               w_wr_ready;
   logic               w_accept;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_COLLECT;
         r_count <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_idx   <= w_idx_next;
      end
   end

   // Staging storage needs no reset; it is only read after a full program lands.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_stage[r_count[c_idx_w-1:0]] <= bus.wr_instr_i;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_idx_next   = r_idx;
      w_wr_ready   = (r_state == S_COLLECT) && !bus.abort_i;
      w_accept     = w_wr_ready && bus.wr_valid_i;
      case (r_state)
         S_COLLECT: begin
            if (bus.abort_i) begin
               w_count_next = '0;
            end else if (w_accept) begin
               w_count_next = r_count + 1'b1;
               if (w_count_next == c_full) begin
                  w_state_next = S_ARMED;
               end
            end
         end
         S_ARMED: begin
            if (bus.abort_i) begin
               w_state_next = S_COLLECT;
               w_count_next = '0;
            end else if (bus.vblank_i) begin
               w_state_next = S_COMMIT;
               w_idx_next   = '0;
            end
         end
         S_COMMIT: begin
            w_idx_next = r_idx + 1'b1;
            if (r_idx == c_last_idx) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_COLLECT;
            w_count_next = '0;
         end
         default: begin
            w_state_next = S_COLLECT;
            w_count_next = '0;
         end
      endcase
   end

   assign bus.wr_ready_o  = w_wr_ready;
   assign bus.mem_shift_o = (r_state == S_COMMIT);
   assign bus.mem_load_o  = (r_state == S_COMMIT);
   assign bus.mem_instr_o = (r_state == S_COMMIT) ? r_stage[r_idx] : '0;
   assign bus.pending_o   = (r_state == S_ARMED);
   assign bus.busy_o      = (r_state == S_COMMIT);
   assign bus.done_o      = (r_state == S_DONE);
   assign bus.stage_cnt_o = r_count;

`ifdef SHADER_CTRL_COMMIT_CNT_EN
   logic [7:0] r_commit_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_commit_cnt <= '0;
      end else if (r_state == S_DONE) begin
         r_commit_cnt <= r_commit_cnt + 8'd1;
      end
   end

   assign commit_cnt_o = r_commit_cnt;
`endif
endmodule
`default_nettype wire
